fetch_predict_unit: RTL and testbench
=====================================

Name: fetch_predict_unit

Overview:
- Fetch-stage producer for the fetch-to-decode pipeline register. It drives Pc_F, PcPlus_F and the instruction-memory address into that register.
- Holds the architectural PC and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so predicted-taken branches are fetched with no bubble.
- Accepts stall from hazard logic and redirect/update from the execute stage, and generates the decode-stage flush on a mispredict.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- BTB_ENTRIES, 16, number of BTB/counter entries; power of two, at least 2.
- IDX_W, $clog2(BTB_ENTRIES), index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; asserted when 0, sampled only on posedge clk.
- stall  in  1  hold PC; same stall that freezes the fetch-to-decode register.
- redirect_valid  in  1  execute stage detected a mispredict.
- redirect_pc  in  32  correct next PC on a mispredict.
- update_valid  in  1  a branch resolved in execute this cycle.
- update_pc  in  32  PC of the resolved branch.
- update_taken  in  1  resolved direction.
- update_target  in  32  resolved taken target.
- imem_addr  out  32  instruction-memory address; equals Pc_F.
- Pc_F  out  32  current fetch PC.
- PcPlus_F  out  32  Pc_F + 4, modulo 2^32.
- pred_taken_F  out  1  prediction for Pc_F; travels down the pipe with the instruction.
- pred_target_F  out  32  predicted target; valid when pred_taken_F=1.
- flush_D  out  1  flush request to the fetch-to-decode register.

Behaviour:
- State per BTB entry:
  - valid bit.
  - tag = pc[31:IDX_W+2].
  - target, 32 bits.
  - cnt, 2 bits.
  - Index is pc[IDX_W+1:2]; pc[1:0] is ignored.
- Prediction (combinational from pc_reg):
  - hit = valid[idx] && tag[idx]==Pc_F tag field.
  - pred_taken_F = hit && cnt[idx][1].
  - pred_target_F = target[idx] when hit, else PcPlus_F.
- Next PC on posedge clk, in priority order:
  1. reset==0 -> RESET_PC.
  2. redirect_valid -> redirect_pc. Redirect overrides stall.
  3. stall -> hold.
  4. pred_taken_F -> pred_target_F.
  5. Otherwise -> PcPlus_F.
- flush_D = redirect_valid, combinational, forced 0 while reset==0. A one-cycle redirect kills exactly the wrong-path instruction being latched into decode.
- BTB update on posedge clk when update_valid && reset==1. Update is independent of stall and redirect.
  - Hit with taken: cnt saturates up to 3; target is rewritten.
  - Hit with not-taken: cnt saturates down to 0; target is unchanged.
  - Miss with taken: allocate the entry (valid=1, new tag, target) with cnt=2.
  - Miss with not-taken: no change.
- Same-index read and write in one cycle: the prediction uses pre-update contents. The write is visible from the next cycle.
- Reset:
  - pc_reg=RESET_PC, all valid=0, all cnt=1.
  - Targets and tags are don't-care.
  - Resulting outputs: Pc_F=RESET_PC, PcPlus_F=RESET_PC+4, pred_taken_F=0, pred_target_F=RESET_PC+4, flush_D=0.
  - Reset mid-operation discards any redirect or update presented in that cycle.
- Wrap-around: PC 32'hFFFF_FFFC advances to 32'h0000_0000. No exception is raised.
- Latency: prediction is zero-cycle, same as Pc_F. Redirect and update take effect at the next edge.

Decomposition:
- Shared package (riscv_pipe_pkg) holds:
  - XLEN=32.
  - PC_STEP=4.
  - Counter constants: CNT_SNT=0, CNT_WNT=1, CNT_WT=2, CNT_ST=3.
  - Saturating-increment and saturating-decrement functions.
- One natural sub-module, btb_predictor. It contains the table arrays, the read port, the update port and the reset-clear logic. The parent fetch_predict_unit holds pc_reg and the next-PC mux.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> Pc_F=0, PcPlus_F=4, pred_taken_F=0, flush_D=0. The PC then advances 0,4,8,12 on successive cycles.
- Stall vs redirect: at Pc_F=0x10, assert stall for 3 cycles -> Pc_F stays 0x10. In the 3rd cycle also assert redirect_valid with redirect_pc=0x80 -> flush_D=1 that cycle and Pc_F=0x80 on the next cycle.
- Allocation and prediction:
  - Present update (update_pc=0x24, update_taken=1, update_target=0x100).
  - Later, when Pc_F reaches 0x24 -> pred_taken_F=1, pred_target_F=0x100, and the next Pc_F is 0x100.
- Counter saturation:
  - From cnt=2 at 0x24, apply 3 taken updates -> cnt=3.
  - Apply one not-taken update -> cnt=2, still predicts taken.
  - Apply a second not-taken update -> cnt=1; Pc_F=0x24 then gives pred_taken_F=0 and next PC 0x28.
- Alias/tag mismatch with BTB_ENTRIES=16: after allocating 0x24, fetch 0x64 (same index, different tag) -> pred_taken_F=0, pred_target_F=0x68.
- Same-cycle update and read: while Pc_F=0x40, apply the first taken update for 0x40 -> pred_taken_F=0 that cycle. On a later fetch of 0x40 -> pred_taken_F=1. Separately, from PC 0xFFFF_FFFC with no stall -> next Pc_F=0x0.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pipe_pkg
// Description : Shared pipeline constants, 2-bit branch-counter encoding and
//               saturating counter helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef logic [1:0] cnt_t;

   localparam cnt_t CNT_SNT = 2'd0;   // strongly not-taken
   localparam cnt_t CNT_WNT = 2'd1;   // weakly not-taken
   localparam cnt_t CNT_WT  = 2'd2;   // weakly taken
   localparam cnt_t CNT_ST  = 2'd3;   // strongly taken

   // Count towards "taken", sticking at the top state.
   function automatic cnt_t sat_inc(input cnt_t c);
      return (c == CNT_ST) ? c : c + 2'd1;
   endfunction

   // Count towards "not-taken", sticking at the bottom state.
   function automatic cnt_t sat_dec(input cnt_t c);
      return (c == CNT_SNT) ? c : c - 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btb_predictor.sv
`default_nettype none
// ============================================================================
// Module      : btb_predictor
// Description : Direct-mapped branch target buffer with per-entry 2-bit
//               saturating counters. Combinational read port, one update
//               port written on the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_predictor
   import riscv_pipe_pkg::*;
#(
   parameter int BTB_ENTRIES = 16,
   parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
   input  logic            clk,
   input  logic            reset,        // synchronous, active-low
   input  logic [XLEN-1:0] rd_pc,
   output logic            rd_hit,
   output cnt_t            rd_cnt,
   output logic [XLEN-1:0] rd_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target
);

   localparam int TAG_W = XLEN - IDX_W - 2;

   logic             valid_q  [BTB_ENTRIES];
   logic             valid_d  [BTB_ENTRIES];
   cnt_t             cnt_q    [BTB_ENTRIES];
   cnt_t             cnt_d    [BTB_ENTRIES];
   logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
   logic [TAG_W-1:0] tag_d    [BTB_ENTRIES];
   logic [XLEN-1:0]  target_q [BTB_ENTRIES];
   logic [XLEN-1:0]  target_d [BTB_ENTRIES];

   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic             unused_pc_lo;

   // Byte offset within the instruction word never selects an entry.
   assign unused_pc_lo = ^{rd_pc[1:0], upd_pc[1:0]};

   assign rd_idx  = rd_pc[IDX_W+1:2];
   assign rd_tag  = rd_pc[XLEN-1:IDX_W+2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

   // Read port: reflects current (pre-update) table contents.
   always_comb begin
      rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
      rd_cnt    = cnt_q[rd_idx];
      rd_target = target_q[rd_idx];
   end

   // Update port: train an existing entry or allocate on a taken miss.
   always_comb begin
      valid_d  = valid_q;
      cnt_d    = cnt_q;
      tag_d    = tag_q;
      target_d = target_q;
      upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      if (upd_valid) begin
         if (upd_hit) begin
            if (upd_taken) begin
               cnt_d[upd_idx]    = sat_inc(cnt_q[upd_idx]);
               target_d[upd_idx] = upd_target;
            end else begin
               cnt_d[upd_idx]    = sat_dec(cnt_q[upd_idx]);
            end
         end else if (upd_taken) begin
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = upd_target;
            cnt_d[upd_idx]    = CNT_WT;
         end
      end
   end

   // Valid bits and counters: cleared to "invalid, weakly not-taken" on reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= CNT_WNT;
         end
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Tags and targets carry no reset; they are only meaningful when valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_q    <= tag_d;
         target_q <= target_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_predict_unit
// Description : Fetch-stage PC generator with BTB-based next-PC prediction,
//               stall hold, execute-stage redirect and decode flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_predict_unit
   import riscv_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BTB_ENTRIES = 16,
   parameter int          IDX_W       = $clog2(BTB_ENTRIES)
) (
   input  logic              clk,
   input  logic              reset,          // synchronous, active-low
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   input  logic              update_valid,
   input  logic [XLEN-1:0]   update_pc,
   input  logic              update_taken,
   input  logic [XLEN-1:0]   update_target,
   output logic [XLEN-1:0]   imem_addr,
   output logic [XLEN-1:0]   Pc_F,
   output logic [XLEN-1:0]   PcPlus_F,
   output logic              pred_taken_F,
   output logic [XLEN-1:0]   pred_target_F,
   output logic              flush_D
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic            btb_hit;
   cnt_t            btb_cnt;
   logic [XLEN-1:0] btb_target;

   btb_predictor #(
      .BTB_ENTRIES (BTB_ENTRIES),
      .IDX_W       (IDX_W)
   ) u_btb (
      .clk        (clk),
      .reset      (reset),
      .rd_pc      (pc_q),
      .rd_hit     (btb_hit),
      .rd_cnt     (btb_cnt),
      .rd_target  (btb_target),
      .upd_valid  (update_valid),
      .upd_pc     (update_pc),
      .upd_taken  (update_taken),
      .upd_target (update_target)
   );

   // Fetch-side outputs and zero-latency prediction for the current PC.
   always_comb begin
      Pc_F          = pc_q;
      imem_addr     = pc_q;
      PcPlus_F      = pc_q + PC_STEP;
      pred_taken_F  = btb_hit && btb_cnt[1];
      pred_target_F = btb_hit ? btb_target : PcPlus_F;
      flush_D       = redirect_valid && reset;
   end

   // Next-PC priority: redirect beats stall, stall beats prediction.
   always_comb begin
      pc_d = PcPlus_F;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (pred_taken_F) begin
         pc_d = pred_target_F;
      end
   end

   // Architectural fetch PC register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_predict_unit
// Description : Directed self-checking bench for fetch_predict_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_predict_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic [31:0] imem_addr;
   logic [31:0] Pc_F;
   logic [31:0] PcPlus_F;
   logic        pred_taken_F;
   logic [31:0] pred_target_F;
   logic        flush_D;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_predict_unit dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .update_valid   (update_valid),
      .update_pc      (update_pc),
      .update_taken   (update_taken),
      .update_target  (update_target),
      .imem_addr      (imem_addr),
      .Pc_F           (Pc_F),
      .PcPlus_F       (PcPlus_F),
      .pred_taken_F   (pred_taken_F),
      .pred_target_F  (pred_target_F),
      .flush_D        (flush_D)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      update_valid   = 1'b0;
      update_pc      = 32'h0;
      update_taken   = 1'b0;
      update_target  = 32'h0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      update_valid  = 1'b1;
      update_pc     = pc;
      update_taken  = tk;
      update_target = tgt;
   endtask

   // Jump the PC with a one-cycle redirect.
   task automatic go(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      idle();
      #1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      // Activity during reset must be discarded and must not flush.
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
      upd(32'h0, 1'b1, 32'h0000_0200);
      tick();
      #1;
      n_checks++; if (flush_D !== 1'b0) begin n_fail++; $display("FAIL reset_flush: flush_D=%b expected 0", flush_D); end
      tick();
      idle();
      reset = 1'b1;
      #1;
      n_checks++; if (Pc_F !== 32'h0) begin n_fail++; $display("FAIL reset_pc: Pc_F=%h expected 00000000", Pc_F); end
      n_checks++; if (PcPlus_F !== 32'h4) begin n_fail++; $display("FAIL reset_pcplus: PcPlus_F=%h expected 00000004", PcPlus_F); end
      n_checks++; if (pred_taken_F !== 1'b0 || pred_target_F !== 32'h4) begin n_fail++; $display("FAIL reset_pred: taken=%b target=%h expected 0/00000004", pred_taken_F, pred_target_F); end
      n_checks++; if (flush_D !== 1'b0) begin n_fail++; $display("FAIL reset_flush_rel: flush_D=%b expected 0", flush_D); end
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks++; if (Pc_F !== 32'(4 * i) || imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc%0d: Pc_F=%h imem_addr=%h expected %h", i, Pc_F, imem_addr, 32'(4 * i)); end
      end
   endtask

   task automatic test_stall_redirect();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++; if (Pc_F !== 32'h10 || flush_D !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: Pc_F=%h flush_D=%b expected 00000010/0", i, Pc_F, flush_D); end
      end
      redirect_valid = 1'b1; redirect_pc = 32'h80;
      #1;
      n_checks++; if (flush_D !== 1'b1) begin n_fail++; $display("FAIL redirect_flush: flush_D=%b expected 1", flush_D); end
      tick();
      idle();
      #1;
      n_checks++; if (Pc_F !== 32'h80) begin n_fail++; $display("FAIL redirect_over_stall: Pc_F=%h expected 00000080", Pc_F); end
      n_checks++; if (flush_D !== 1'b0) begin n_fail++; $display("FAIL flush_one_cycle: flush_D=%b expected 0", flush_D); end
   endtask

   task automatic test_alloc_predict();
      upd(32'h24, 1'b1, 32'h100);
      go(32'h20);
      n_checks++; if (pred_taken_F !== 1'b0 || pred_target_F !== 32'h24) begin n_fail++; $display("FAIL alloc_neighbour: taken=%b target=%h expected 0/00000024", pred_taken_F, pred_target_F); end
      tick();
      n_checks++; if (Pc_F !== 32'h24 || pred_taken_F !== 1'b1 || pred_target_F !== 32'h100) begin n_fail++; $display("FAIL alloc_hit: pc=%h taken=%b target=%h expected 00000024/1/00000100", Pc_F, pred_taken_F, pred_target_F); end
      tick();
      n_checks++; if (Pc_F !== 32'h100) begin n_fail++; $display("FAIL alloc_follow: Pc_F=%h expected 00000100", Pc_F); end
   endtask

   task automatic test_alias();
      go(32'h64);
      n_checks++; if (pred_taken_F !== 1'b0 || pred_target_F !== 32'h68) begin n_fail++; $display("FAIL alias: taken=%b target=%h expected 0/00000068", pred_taken_F, pred_target_F); end
      tick();
      n_checks++; if (Pc_F !== 32'h68) begin n_fail++; $display("FAIL alias_next: Pc_F=%h expected 00000068", Pc_F); end
   endtask

   task automatic test_counter();
      // Park at 0x24 (cnt=2) and train the entry while stalled there.
      go(32'h24);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         upd(32'h24, 1'b1, 32'h100);
         tick();
      end
      upd(32'h24, 1'b0, 32'h0);                 // 3 -> 2, this cycle still sees 3
      #1;
      n_checks++; if (Pc_F !== 32'h24 || pred_taken_F !== 1'b1) begin n_fail++; $display("FAIL cnt_sat_hi: pc=%h taken=%b expected 00000024/1", Pc_F, pred_taken_F); end
      tick();
      upd(32'h24, 1'b0, 32'h0);                 // 2 -> 1
      #1;
      n_checks++; if (pred_taken_F !== 1'b1) begin n_fail++; $display("FAIL cnt_wt: taken=%b expected 1", pred_taken_F); end
      tick();
      n_checks++; if (pred_taken_F !== 1'b0 || pred_target_F !== 32'h100) begin n_fail++; $display("FAIL cnt_wnt: taken=%b target=%h expected 0/00000100", pred_taken_F, pred_target_F); end
      upd(32'h24, 1'b0, 32'h0);                 // 1 -> 0
      tick();
      upd(32'h24, 1'b0, 32'h0);                 // 0 stays 0
      tick();
      upd(32'h24, 1'b1, 32'h200);               // 0 -> 1, target rewritten
      tick();
      idle();
      #1;
      n_checks++; if (pred_taken_F !== 1'b0 || pred_target_F !== 32'h200) begin n_fail++; $display("FAIL cnt_sat_lo: taken=%b target=%h expected 0/00000200", pred_taken_F, pred_target_F); end
      tick();
      n_checks++; if (Pc_F !== 32'h28) begin n_fail++; $display("FAIL cnt_fallthru: Pc_F=%h expected 00000028", Pc_F); end
   endtask

   task automatic test_same_cycle();
      go(32'h40);
      upd(32'h40, 1'b1, 32'h300);
      #1;
      n_checks++; if (pred_taken_F !== 1'b0 || pred_target_F !== 32'h44) begin n_fail++; $display("FAIL same_cycle: taken=%b target=%h expected 0/00000044", pred_taken_F, pred_target_F); end
      tick();
      idle();
      #1;
      n_checks++; if (Pc_F !== 32'h44) begin n_fail++; $display("FAIL same_cycle_next: Pc_F=%h expected 00000044", Pc_F); end
      go(32'h40);
      n_checks++; if (pred_taken_F !== 1'b1 || pred_target_F !== 32'h300) begin n_fail++; $display("FAIL later_fetch: taken=%b target=%h expected 1/00000300", pred_taken_F, pred_target_F); end
      // Redirect must beat a taken prediction.
      go(32'h500);
      n_checks++; if (Pc_F !== 32'h500) begin n_fail++; $display("FAIL redirect_over_pred: Pc_F=%h expected 00000500", Pc_F); end
   endtask

   task automatic test_wrap();
      go(32'hFFFF_FFFC);
      n_checks++; if (PcPlus_F !== 32'h0 || pred_taken_F !== 1'b0) begin n_fail++; $display("FAIL wrap_plus: PcPlus_F=%h taken=%b expected 00000000/0", PcPlus_F, pred_taken_F); end
      tick();
      n_checks++; if (Pc_F !== 32'h0) begin n_fail++; $display("FAIL wrap_next: Pc_F=%h expected 00000000", Pc_F); end
   endtask

   task automatic test_mid_reset();
      go(32'h40);
      reset = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h900;
      upd(32'h0, 1'b1, 32'h700);
      #1;
      n_checks++; if (flush_D !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flush: flush_D=%b expected 0", flush_D); end
      tick();
      idle();
      reset = 1'b1;
      #1;
      n_checks++; if (Pc_F !== 32'h0 || pred_taken_F !== 1'b0 || pred_target_F !== 32'h4) begin n_fail++; $display("FAIL mid_reset: pc=%h taken=%b target=%h expected 00000000/0/00000004", Pc_F, pred_taken_F, pred_target_F); end
      go(32'h40);
      n_checks++; if (pred_taken_F !== 1'b0) begin n_fail++; $display("FAIL mid_reset_clear: taken=%b expected 0", pred_taken_F); end
   endtask

   initial begin
      reset = 1'b0;
      idle();
      #1;
      test_reset();
      test_stall_redirect();
      test_alloc_predict();
      test_alias();
      test_counter();
      test_same_cycle();
      test_wrap();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
